// File: rtl/des_pkg.sv
// Shared types and helpers for the DES byte-stream / CBC front end.
package des_pkg;

    typedef logic [63:0] des_block_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic MODE_ECB = 1'b0;
    localparam logic MODE_CBC = 1'b1;

    // Optional XOR with the chain register; used on both sides of the core.
    function automatic des_block_t chain_mix(
        input des_block_t data,
        input des_block_t chain,
        input logic       en
    );
        des_block_t res;
        if (en) begin
            res = data ^ chain;
        end else begin
            res = data;
        end
        return res;
    endfunction

endpackage

// File: rtl/des_byte_packer.sv
// Packs eight accepted bytes MSB-first into a 64-bit block and
// exposes the handshake, first-byte and block-complete strobes.
module des_byte_packer
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       fill_en,
    input  logic       hold,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       first,
    output logic       full,
    output logic       count_zero,
    output des_block_t block_next,
    output des_block_t block
);

    logic [2:0] count_r;
    des_block_t block_r;
    logic       alive_r;
    logic       accept_s;

    // hold (iv_load) only blocks the byte slot at a block boundary
    assign count_zero = (count_r == 3'd0);
    assign byte_ready = alive_r && fill_en && !(hold && count_zero);
    assign accept_s   = byte_valid && byte_ready;
    assign first      = accept_s && count_zero;
    assign full       = accept_s && (count_r == 3'd7);
    assign block_next = {block_r[55:0], byte_in};
    assign block      = block_r;

    // Keeps byte_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alive_r <= 1'b0;
        end else begin
            alive_r <= 1'b1;
        end
    end

    // Shift register and byte counter; the count wraps to 0 on the 8th byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= 3'd0;
            block_r <= 64'd0;
        end else if (accept_s) begin
            count_r <= count_r + 3'd1;
            block_r <= block_next;
        end else begin
            count_r <= count_r;
            block_r <= block_r;
        end
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// Byte-stream front end for a DES core: packs blocks, issues them to the
// core, applies ECB/CBC chaining and guards the core with a watchdog.
module des_cbc_ctrl
    import des_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [63:0] key_in,
    input  logic        mode_cbc,
    input  logic        decrypt_in,
    input  logic [63:0] iv,
    input  logic        iv_load,
    output logic [63:0] plain_text,
    output logic [63:0] cipher_key,
    output logic        encrypt_decrypt,
    output logic        valid_in,
    input  logic [63:0] cipher_text,
    input  logic        valid_out,
    output logic [63:0] block_out,
    output logic        block_valid,
    input  logic        block_ready,
    output logic        timeout_err
);

    state_t          state_r;
    state_t          state_nx_s;
    des_block_t      key_r;
    logic            mode_r;
    logic            dec_r;
    des_block_t      chain_r;
    logic [TO_W-1:0] wd_r;

    logic            first_s;
    logic            full_s;
    logic            count_zero_s;
    des_block_t      block_next_s;
    des_block_t      block_s;
    logic            iv_take_s;
    logic            result_s;
    logic            wd_expire_s;
    logic            cbc_enc_s;
    logic            cbc_dec_s;

    des_byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .fill_en    (state_r == FILL),
        .hold       (iv_load),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .first      (first_s),
        .full       (full_s),
        .count_zero (count_zero_s),
        .block_next (block_next_s),
        .block      (block_s)
    );

    assign cbc_enc_s   = (mode_r == MODE_CBC) && !dec_r;
    assign cbc_dec_s   = (mode_r == MODE_CBC) && dec_r;
    assign iv_take_s   = iv_load && (state_r == FILL) && count_zero_s;
    assign result_s    = (state_r == WAIT) && valid_out;
    // wd_r counts cycles since the valid_in pulse; expiry lands exactly TIMEOUT_CYCLES later
    assign wd_expire_s = (state_r == WAIT) && !valid_out
                         && (wd_r == TO_W'(TIMEOUT_CYCLES - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state selection for the block sequencing FSM
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            FILL: begin
                if (full_s) begin
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = FILL;
                end
            end
            ISSUE: begin
                state_nx_s = WAIT;
            end
            WAIT: begin
                if (valid_out) begin
                    state_nx_s = OUT;
                end else if (wd_expire_s) begin
                    state_nx_s = FILL;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            OUT: begin
                if (block_ready) begin
                    state_nx_s = FILL;
                end else begin
                    state_nx_s = OUT;
                end
            end
            default: begin
                state_nx_s = FILL;
            end
        endcase
    end

    // Per-block controls captured with byte 0 so mid-block changes are ignored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_r  <= 64'd0;
            mode_r <= MODE_ECB;
            dec_r  <= 1'b0;
        end else if (first_s) begin
            key_r  <= key_in;
            mode_r <= mode_cbc;
            dec_r  <= decrypt_in;
        end else begin
            key_r  <= key_r;
            mode_r <= mode_r;
            dec_r  <= dec_r;
        end
    end

    // Core request registers; held stable from ISSUE until the next block completes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            plain_text      <= 64'd0;
            cipher_key      <= 64'd0;
            encrypt_decrypt <= 1'b0;
            valid_in        <= 1'b0;
        end else begin
            valid_in <= full_s;
            if (full_s) begin
                plain_text      <= chain_mix(block_next_s, chain_r, cbc_enc_s);
                cipher_key      <= key_r;
                encrypt_decrypt <= dec_r;
            end else begin
                plain_text      <= plain_text;
                cipher_key      <= cipher_key;
                encrypt_decrypt <= encrypt_decrypt;
            end
        end
    end

    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_r        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_r == ISSUE) begin
                wd_r <= TO_W'(1);
            end else if ((state_r == WAIT) && !valid_out) begin
                wd_r <= wd_r + TO_W'(1);
            end else begin
                wd_r <= wd_r;
            end
            if (wd_expire_s) begin
                timeout_err <= 1'b1;
            end else if (iv_take_s) begin
                timeout_err <= 1'b0;
            end else begin
                timeout_err <= timeout_err;
            end
        end
    end

    // Result capture and valid/ready output handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            block_out   <= 64'd0;
            block_valid <= 1'b0;
        end else if (result_s) begin
            block_out   <= chain_mix(cipher_text, chain_r, cbc_dec_s);
            block_valid <= 1'b1;
        end else if ((state_r == OUT) && block_ready) begin
            block_out   <= block_out;
            block_valid <= 1'b0;
        end else begin
            block_out   <= block_out;
            block_valid <= block_valid;
        end
    end

    // CBC chain: IV load at block boundary, else feedback from the finished block
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_r <= 64'd0;
        end else if (iv_take_s) begin
            chain_r <= iv;
        end else if (result_s && cbc_enc_s) begin
            chain_r <= cipher_text;
        end else if (result_s && cbc_dec_s) begin
            chain_r <= block_s;
        end else begin
            chain_r <= chain_r;
        end
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Self-checking bench for des_cbc_ctrl against a latency-configurable DES stub
// and a block-level ECB/CBC reference model.
module tb_des_cbc_ctrl;

    localparam int          TO = 64;
    localparam logic [63:0] K0 = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] P0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] C0 = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [63:0] key_in = 64'd0;
    logic        mode_cbc = 1'b0;
    logic        decrypt_in = 1'b0;
    logic [63:0] iv = 64'd0;
    logic        iv_load = 1'b0;
    logic [63:0] plain_text;
    logic [63:0] cipher_key;
    logic        encrypt_decrypt;
    logic        valid_in;
    logic [63:0] cipher_text;
    logic        valid_out;
    logic [63:0] block_out;
    logic        block_valid;
    logic        block_ready = 1'b0;
    logic        timeout_err;

    int checks_total = 0;
    int checks_passed = 0;
    logic [63:0] chain_m = 64'd0;

    // DES core stub
    int          stub_lat = 3;
    logic        stub_en = 1'b1;
    logic        stub_busy = 1'b0;
    int          stub_cnt = 0;
    logic        stub_vo = 1'b0;
    logic [63:0] stub_ct = 64'd0;
    logic        vo_force = 1'b0;

    always #5 clk = ~clk;

    des_cbc_ctrl dut (
        .clk(clk), .rstn(rstn), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .key_in(key_in), .mode_cbc(mode_cbc),
        .decrypt_in(decrypt_in), .iv(iv), .iv_load(iv_load),
        .plain_text(plain_text), .cipher_key(cipher_key),
        .encrypt_decrypt(encrypt_decrypt), .valid_in(valid_in),
        .cipher_text(cipher_text), .valid_out(valid_out), .block_out(block_out),
        .block_valid(block_valid), .block_ready(block_ready), .timeout_err(timeout_err)
    );

    // Stand-in cipher: the real DES answer for the reference vector, an involution elsewhere
    function automatic logic [63:0] core_model(input logic [63:0] pt, input logic [63:0] key, input logic dec);
        if (!dec && pt == P0 && key == K0) return C0;
        if (dec && pt == C0 && key == K0) return P0;
        return pt ^ {key[31:0], key[63:32]} ^ 64'h5A5A_3C3C_0F0F_9669;
    endfunction

    always @(posedge clk) begin
        stub_vo <= 1'b0;
        if (valid_in) begin
            stub_busy <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_ct   <= core_model(plain_text, cipher_key, encrypt_decrypt);
        end else if (stub_busy) begin
            if (stub_cnt <= 1) begin
                stub_busy <= 1'b0;
                stub_vo   <= stub_en;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    assign valid_out   = stub_vo | vo_force;
    assign cipher_text = vo_force ? JUNK : stub_ct;

    task automatic send_bytes(input logic [63:0] blk, input logic [63:0] key, input logic cbc,
                              input logic dec, input bit gaps);
        int n;
        for (int i = 0; i < 8; i++) begin
            byte_in = blk[63-8*i -: 8];
            byte_valid = 1'b1;
            if (i == 0) begin
                key_in = key; mode_cbc = cbc; decrypt_in = dec;
            end else begin
                key_in = {$urandom, $urandom}; mode_cbc = 1'($urandom); decrypt_in = 1'($urandom);
            end
            #1;
            n = 0;
            while (!byte_ready && n < 300) begin @(posedge clk); #1; n++; end
            checks_total++;
            if (!byte_ready) $display("FAIL byte_accept byte %0d: byte_ready=%b required 1", i, byte_ready);
            else checks_passed++;
            @(posedge clk); #1;
            byte_valid = 1'b0;
            if (gaps && i < 7 && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic run_block(input logic [63:0] blk, input logic [63:0] key, input logic cbc,
                             input logic dec, input int hold, input bit gaps, input bit spur);
        logic [63:0] pt_e, out_e, ct;
        int n, pulses;
        pt_e = (cbc && !dec) ? (blk ^ chain_m) : blk;
        ct = core_model(pt_e, key, dec);
        out_e = (cbc && dec) ? (ct ^ chain_m) : ct;
        if (cbc) chain_m = dec ? blk : ct;
        send_bytes(blk, key, cbc, dec, gaps);
        checks_total++;
        if (valid_in !== 1'b1 || plain_text !== pt_e || cipher_key !== key || encrypt_decrypt !== dec)
            $display("FAIL issue: valid_in=%b pt=%h key=%h dir=%b required 1 %h %h %b",
                     valid_in, plain_text, cipher_key, encrypt_decrypt, pt_e, key, dec);
        else checks_passed++;
        pulses = 1; n = 0;
        while (!block_valid && n < 200) begin
            @(posedge clk); #1; n++;
            if (valid_in) pulses++;
        end
        checks_total++;
        if (!block_valid || pulses != 1 || plain_text !== pt_e)
            $display("FAIL completion: block_valid=%b valid_in_pulses=%0d pt=%h required 1 1 %h",
                     block_valid, pulses, plain_text, pt_e);
        else checks_passed++;
        checks_total++;
        if (block_out !== out_e) $display("FAIL block_out: got %h required %h", block_out, out_e);
        else checks_passed++;
        for (int h = 0; h < hold; h++) begin
            vo_force = spur && (h == hold / 2);
            @(posedge clk); #1;
            vo_force = 1'b0;
            checks_total++;
            if (block_valid !== 1'b1 || block_out !== out_e || byte_ready !== 1'b0 || valid_in !== 1'b0)
                $display("FAIL hold cycle %0d: valid=%b out=%h byte_ready=%b required 1 %h 0",
                         h, block_valid, block_out, byte_ready, out_e);
            else checks_passed++;
        end
        block_ready = 1'b1;
        @(posedge clk); #1;
        block_ready = 1'b0;
        checks_total++;
        if (block_valid !== 1'b0 || byte_ready !== 1'b1)
            $display("FAIL release: block_valid=%b byte_ready=%b required 0 1", block_valid, byte_ready);
        else checks_passed++;
    endtask

    task automatic do_iv_load(input logic [63:0] v);
        iv = v; iv_load = 1'b1; byte_valid = 1'b1; byte_in = 8'($urandom);
        #1;
        checks_total++;
        if (byte_ready !== 1'b0) $display("FAIL iv_priority: byte_ready=%b required 0", byte_ready);
        else checks_passed++;
        @(posedge clk); #1;
        iv_load = 1'b0; byte_valid = 1'b0;
        chain_m = v;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks_total++;
        if (byte_ready !== 1'b0 || valid_in !== 1'b0 || block_valid !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL reset_ctrl: ready=%b vin=%b bvalid=%b terr=%b required 0 0 0 0",
                     byte_ready, valid_in, block_valid, timeout_err);
        else checks_passed++;
        checks_total++;
        if (plain_text !== 64'd0 || cipher_key !== 64'd0 || block_out !== 64'd0 || encrypt_decrypt !== 1'b0)
            $display("FAIL reset_data: pt=%h key=%h out=%h dir=%b required zeros",
                     plain_text, cipher_key, block_out, encrypt_decrypt);
        else checks_passed++;
        rstn = 1'b1;
        @(posedge clk); #1;
        checks_total++;
        if (byte_ready !== 1'b1) $display("FAIL ready_after_reset: got %b required 1", byte_ready);
        else checks_passed++;
        chain_m = 64'd0;
    endtask

    task automatic test_ecb_vector;
        stub_lat = 5;
        run_block(P0, K0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_cbc_enc;
        stub_lat = 2;
        do_iv_load(64'd0);
        run_block(P0, K0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        run_block(C0, K0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_cbc_dec;
        stub_lat = 7;
        do_iv_load(64'd0);
        run_block(C0, K0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        run_block({$urandom, $urandom}, K0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        stub_lat = 4;
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 20, 1'b0, 1'b1);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        for (int b = 0; b < 14; b++) begin
            stub_lat = $urandom_range(1, 12);
            if ($urandom_range(0, 3) == 0) do_iv_load({$urandom, $urandom});
            run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 4), 1'b1, 1'($urandom));
        end
    endtask

    task automatic test_timeout;
        int n;
        logic [63:0] new_iv;
        stub_en = 1'b0; stub_lat = 3;
        send_bytes({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        checks_total++;
        if (valid_in !== 1'b1) $display("FAIL timeout_issue: valid_in=%b required 1", valid_in);
        else checks_passed++;
        n = 0;
        while (!timeout_err && n < 200) begin @(posedge clk); #1; n++; end
        checks_total++;
        if (n != TO) $display("FAIL timeout_cycles: got %0d required %0d", n, TO);
        else checks_passed++;
        checks_total++;
        if (byte_ready !== 1'b1 || block_valid !== 1'b0)
            $display("FAIL timeout_state: byte_ready=%b block_valid=%b required 1 0", byte_ready, block_valid);
        else checks_passed++;
        stub_en = 1'b1;
        new_iv = {$urandom, $urandom};
        do_iv_load(new_iv);
        checks_total++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear: got %b required 0", timeout_err);
        else checks_passed++;
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait;
        int seen;
        stub_lat = 20;
        send_bytes({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks_total++;
        if (valid_in !== 1'b0 || plain_text !== 64'd0 || cipher_key !== 64'd0 || byte_ready !== 1'b0
            || block_valid !== 1'b0 || timeout_err !== 1'b0)
            $display("FAIL midwait_reset: vin=%b pt=%h key=%h ready=%b bvalid=%b required all 0",
                     valid_in, plain_text, cipher_key, byte_ready, block_valid);
        else checks_passed++;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        chain_m = 64'd0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (block_valid || valid_in) seen++;
        end
        checks_total++;
        if (seen != 0) $display("FAIL late_valid_out: spurious activity cycles=%0d required 0", seen);
        else checks_passed++;
        stub_lat = 3;
        run_block({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_ecb_vector();
        test_cbc_enc();
        test_cbc_dec();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
